seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pkg.sv | 12 +
 rtl/seq_shift_reg.sv | 59 +++++
 rtl/seq_pattern_tx.sv | 129 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [3:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_shift_reg.sv
// Frame shift register with bit counter; next_bit is the bit that follows the one currently on the line.
// Build option SEQ_TX_PARITY_EN appends an even-parity bit after the PAT_W pattern bits.
module seq_shift_reg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pat,
  output logic             next_bit,
  output logic             last_bit
);

`ifdef SEQ_TX_PARITY_EN
  localparam int NBITS = PAT_W + 1;
`else
  localparam int NBITS = PAT_W;
`endif
  localparam int CNT_W = $clog2(NBITS);

  logic [PAT_W-1:0] data_q;
  logic [PAT_W-1:0] data_sh;
  logic [CNT_W-1:0] cnt_q;

  assign data_sh  = data_q << 1;
  assign last_bit = (cnt_q == CNT_W'(NBITS - 1));

`ifdef SEQ_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^pat;
    end
  end

  // After the last pattern bit the parity bit goes out instead of shifted-in zeros.
  assign next_bit = (cnt_q == CNT_W'(PAT_W - 1)) ? par_q : data_sh[PAT_W-1];
`else
  assign next_bit = data_sh[PAT_W-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      data_q <= pat;
      cnt_q  <= '0;
    end else if (shift) begin
      data_q <= data_sh;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern burst transmitter: repeat+1 frames, MSB first, optional idle gap between frames.
// Build option SEQ_TX_PARITY_EN (implemented in seq_shift_reg) adds a trailing even-parity bit per frame.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int RPT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [RPT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, load_pat;
  logic [RPT_W-1:0] frm_q, frm_d;
  logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
  logic             dout_q, dout_d, vld_q, vld_d, busy_q, busy_d, done_q, done_d;
  logic             sr_load, sr_shift, next_bit, last_bit;

  seq_shift_reg #(.PAT_W(PAT_W)) u_sr (
    .clk      (clk),
    .reset    (reset),
    .load     (sr_load),
    .shift    (sr_shift),
    .pat      (load_pat),
    .next_bit (next_bit),
    .last_bit (last_bit)
  );

  // Outputs are computed one cycle ahead so dout/dout_vld come straight from flops.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    frm_d    = frm_q;
    gap_d    = gap_q;
    gcnt_d   = gcnt_q;
    dout_d   = 1'b0;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    load_pat = pat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SEND;
          pat_d    = pattern;
          frm_d    = repeat_cnt;
          gap_d    = gap;
          load_pat = pattern;
          sr_load  = 1'b1;
          dout_d   = pattern[PAT_W-1];
          vld_d    = 1'b1;
        end
      end
      SEND: begin
        if (!last_bit) begin
          sr_shift = 1'b1;
          dout_d   = next_bit;
          vld_d    = 1'b1;
        end else if (frm_q != '0) begin
          frm_d = frm_q - 1'b1;
          if (gap_q == '0) begin
            sr_load = 1'b1;
            dout_d  = pat_q[PAT_W-1];
            vld_d   = 1'b1;
          end else begin
            state_d = GAP;
            gcnt_d  = gap_q;
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (gcnt_q == GAP_W'(1)) begin
          state_d = SEND;
          sr_load = 1'b1;
          dout_d  = pat_q[PAT_W-1];
          vld_d   = 1'b1;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      frm_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      frm_q   <= frm_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx; expected streams are hand-written for both SEQ_TX_PARITY_EN builds.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic [3:0] repeat_v = 4'd0;
  logic [2:0] gap = 3'd0;
  logic       dout, dout_vld, busy, done;

  int n_chk = 0;
  int n_err = 0;
  int det_st;
  int det_cnt;
  int busy_cnt;

  seq_pattern_tx #(.PAT_W(4), .RPT_W(4), .GAP_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_v),
    .gap        (gap),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Non-overlapping Mealy detector for 1011, clocked on valid bits only.
  task automatic det_step(input logic b);
    case (det_st)
      0: det_st = b ? 1 : 0;
      1: det_st = b ? 1 : 2;
      2: det_st = b ? 3 : 0;
      default: begin
        if (b) begin
          det_cnt++;
          det_st = 0;
        end else begin
          det_st = 2;
        end
      end
    endcase
  endtask

  // Starts a burst in the current cycle, checks n line cycles, then the done cycle.
  // disturb >= 0 pulses start and scrambles the inputs at that cycle index.
  task automatic burst(input string tag, input logic [3:0] pat, input logic [3:0] rep,
                       input logic [2:0] g, input int n, input logic [31:0] exp_d,
                       input logic [31:0] exp_v, input int disturb);
    pattern  = pat;
    repeat_v = rep;
    gap      = g;
    start    = 1'b1;
    det_st   = 0;
    det_cnt  = 0;
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      if (i == disturb) begin
        start    = 1'b1;
        pattern  = 4'b0000;
        repeat_v = 4'hF;
        gap      = 3'd7;
      end else if (i == disturb + 1) begin
        start = 1'b0;
      end
      chk($sformatf("%s dout[%0d]", tag, i), {31'd0, dout}, {31'd0, exp_d[n-1-i]});
      chk($sformatf("%s vld[%0d]", tag, i), {31'd0, dout_vld}, {31'd0, exp_v[n-1-i]});
      if (i > 0) chk($sformatf("%s done_early[%0d]", tag, i), {31'd0, done}, 32'd0);
      if (busy) busy_cnt++;
      if (dout_vld) det_step(dout);
    end
    tick();
    chk({tag, " busy_cycles"}, busy_cnt, n);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, " vld_end"}, {31'd0, dout_vld}, 32'd0);
    chk({tag, " dout_end"}, {31'd0, dout}, 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst dout", {31'd0, dout}, 32'd0);
    chk("rst vld", {31'd0, dout_vld}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle busy", {31'd0, busy}, 32'd0);

    // Single frame, then a new burst requested in the done cycle
`ifdef SEQ_TX_PARITY_EN
    burst("single", DEF_PATTERN, 4'd0, 3'd0, 5, 32'b10111, 32'b11111, -1);
    burst("chain", 4'b1001, 4'd0, 3'd0, 5, 32'b10010, 32'b11111, -1);
`else
    burst("single", DEF_PATTERN, 4'd0, 3'd0, 4, 32'b1011, 32'b1111, -1);
    burst("chain", 4'b1001, 4'd0, 3'd0, 4, 32'b1001, 32'b1111, -1);
`endif
    tick();
    chk("chain done_drop", {31'd0, done}, 32'd0);
    chk("chain idle vld", {31'd0, dout_vld}, 32'd0);

    // Three frames with a one-cycle gap
`ifdef SEQ_TX_PARITY_EN
    burst("gap1", 4'b1011, 4'd2, 3'd1, 17, 32'b10111010111010111, 32'b11111011111011111, -1);
`else
    burst("gap1", 4'b1011, 4'd2, 3'd1, 14, 32'b10110101101011, 32'b11110111101111, -1);
`endif
    tick();
    chk("gap1 done_drop", {31'd0, done}, 32'd0);

    // Three frames back-to-back, checked through the 1011 detector
`ifdef SEQ_TX_PARITY_EN
    burst("b2b", 4'b1011, 4'd2, 3'd0, 15, 32'b101111011110111, 32'h7FFF, -1);
`else
    burst("b2b", 4'b1011, 4'd2, 3'd0, 12, 32'b101110111011, 32'hFFF, -1);
`endif
    chk("b2b detections", det_cnt, 3);
    tick();

    // Start and input changes while busy are ignored
`ifdef SEQ_TX_PARITY_EN
    burst("ignore", 4'b1011, 4'd1, 3'd0, 10, 32'b1011110111, 32'h3FF, 2);
`else
    burst("ignore", 4'b1011, 4'd1, 3'd0, 8, 32'b10111011, 32'hFF, 2);
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ignore no_rerun vld[%0d]", i), {31'd0, dout_vld}, 32'd0);
      chk($sformatf("ignore no_rerun busy[%0d]", i), {31'd0, busy}, 32'd0);
    end

    // Reset during the second bit of a four-frame burst
    pattern  = 4'b1011;
    repeat_v = 4'd3;
    gap      = 3'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("abort bit1", {31'd0, dout}, 32'd1);
    tick();
    chk("abort bit2 dout", {31'd0, dout}, 32'd0);
    chk("abort bit2 vld", {31'd0, dout_vld}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort dout", {31'd0, dout}, 32'd0);
    chk("abort vld", {31'd0, dout_vld}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("abort quiet done[%0d]", i), {31'd0, done}, 32'd0);
      chk($sformatf("abort quiet vld[%0d]", i), {31'd0, dout_vld}, 32'd0);
    end

    // Reset wins over a simultaneous start
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    chk("rst_prio vld", {31'd0, dout_vld}, 32'd0);
    chk("rst_prio busy", {31'd0, busy}, 32'd0);
    tick();
    chk("rst_prio idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
